// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave acting as a register-bus master for command/address frames.
// Supports burst reads with prefetch, burst writes, auto-increment and abort detection.
module spi_reg_bridge #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          AUTO_INC    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [7:0]        reg_rdata,
   output logic [7:0]        rx_byte,
   output logic              rx_valid,
   output logic              busy,
   output logic              frame_err
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      RD_FETCH,
      RD_DATA,
      WR_DATA
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [6:0]             shift_q;
   logic [6:0]             tx_q;
   logic [2:0]             bitcnt_q;
   logic [1:0]             fetch_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [ADDR_W-1:0]      addr_d;
   logic                   wr_pend_q;

   logic                   miso_q;
   logic [ADDR_W-1:0]      reg_addr_q;
   logic [7:0]             reg_wdata_q;
   logic                   reg_wr_q;
   logic                   reg_rd_q;
   logic [7:0]             rx_byte_q;
   logic                   rx_valid_q;
   logic                   busy_q;
   logic                   frame_err_q;

   logic                   sclk_cur;
   logic                   sclk_prv;
   logic                   cs_cur;
   logic                   cs_prv;
   logic                   mosi_cur;
   logic                   cs_rise;
   logic                   cs_fall;
   logic                   active;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   byte_done;
   logic [7:0]             full_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   // MOSI is stable long before a rise, so the oldest stage is safe to sample
   assign sclk_cur  = sclk_sync_q[SYNC_STAGES-2];
   assign sclk_prv  = sclk_sync_q[SYNC_STAGES-1];
   assign cs_cur    = cs_sync_q[SYNC_STAGES-2];
   assign cs_prv    = cs_sync_q[SYNC_STAGES-1];
   assign mosi_cur  = mosi_sync_q[SYNC_STAGES-1];

   assign cs_rise   = cs_cur & ~cs_prv;
   assign cs_fall   = ~cs_cur & cs_prv;
   assign active    = (state_q != IDLE);
   assign sclk_rise = active & ~cs_rise & sclk_cur & ~sclk_prv;
   assign sclk_fall = active & ~cs_rise & ~sclk_cur & sclk_prv;
   assign byte_done = sclk_rise & (bitcnt_q == 3'd7);
   assign full_byte = {shift_q, mosi_cur};
   assign addr_d    = AUTO_INC ? addr_q + ADDR_W'(1) : addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         tx_q        <= '0;
         bitcnt_q    <= '0;
         fetch_q     <= '0;
         addr_q      <= '0;
         wr_pend_q   <= 1'b0;
         miso_q      <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         reg_wr_q   <= 1'b0;
         reg_rd_q   <= 1'b0;

         // a completed write byte is committed even if CS rises meanwhile
         if (wr_pend_q) begin
            wr_pend_q   <= 1'b0;
            reg_wr_q    <= 1'b1;
            reg_wdata_q <= rx_byte_q;
            reg_addr_q  <= addr_q;
            addr_q      <= addr_d;
         end

         if (sclk_rise) begin
            shift_q  <= full_byte[6:0];
            bitcnt_q <= bitcnt_q + 3'd1;
         end

         if (byte_done) begin
            rx_byte_q  <= full_byte;
            rx_valid_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q     <= CMD;
                  busy_q      <= 1'b1;
                  frame_err_q <= 1'b0;
                  bitcnt_q    <= '0;
                  shift_q     <= '0;
                  miso_q      <= 1'b0;
               end
            end
            CMD: begin
               if (byte_done) begin
                  addr_q  <= full_byte[ADDR_W-1:0];
                  fetch_q <= '0;
                  state_q <= full_byte[7] ? RD_FETCH : WR_DATA;
               end
            end
            RD_FETCH: begin
               fetch_q <= fetch_q + 2'd1;
               if (fetch_q == 2'd0) begin
                  reg_rd_q   <= 1'b1;
                  reg_addr_q <= addr_q;
               end
               if (fetch_q == 2'd2) begin
                  tx_q    <= reg_rdata[6:0];
                  miso_q  <= reg_rdata[7];
                  state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               // the fall after a byte boundary keeps the freshly loaded MSB
               if (sclk_fall && (bitcnt_q != 3'd0)) begin
                  miso_q <= tx_q[6];
                  tx_q   <= {tx_q[5:0], 1'b0};
               end
               if (byte_done) begin
                  addr_q  <= addr_d;
                  fetch_q <= '0;
                  state_q <= RD_FETCH;
               end
            end
            WR_DATA: begin
               if (byte_done) begin
                  wr_pend_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (cs_rise && active) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            miso_q   <= 1'b0;
            bitcnt_q <= '0;
            if (bitcnt_q != 3'd0) begin
               frame_err_q <= 1'b1;
            end
         end
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = busy_q;
   assign reg_addr    = reg_addr_q;
   assign reg_wdata   = reg_wdata_q;
   assign reg_wr      = reg_wr_q;
   assign reg_rd      = reg_rd_q;
   assign rx_byte     = rx_byte_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = busy_q;
   assign frame_err   = frame_err_q;

endmodule
